// File: rtl/cache_prof_pkg.sv
// Shared types and defaults for the cache event profiler.
// Read-kind encoding and parameter defaults.
package cache_prof_pkg;

  typedef enum logic [1:0] {
    KIND_HIT   = 2'd0,
    KIND_REQ   = 2'd1,
    KIND_MISS  = 2'd2,
    KIND_FLAGS = 2'd3
  } rd_kind_t;

  localparam int NUM_CACHES_DEF = 2;
  localparam int CNT_W_DEF      = 32;

endpackage

// File: rtl/prof_edge_counter.sv
// One strobe: rising-edge detector, live counter, sticky overflow flag.
// In: clk, rst_n, enable, clear, strobe. Out: count_o, flag_o.
// CACHE_PROF_SATURATE_EN: saturate at all-ones instead of wrapping.
module prof_edge_counter
  import cache_prof_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             strobe,
  output logic [CNT_W-1:0] count_o,
  output logic             flag_o
);

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             evt;
  logic             at_max;

  always_comb begin
    evt    = strobe & ~prev_q & enable;
    at_max = &cnt_q;
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (evt) begin
      if (at_max) flag_d = 1'b1;
`ifdef CACHE_PROF_SATURATE_EN
      if (!at_max) cnt_d = cnt_q + CNT_W'(1);
`else
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end
  end

  // prev tracks the strobe even when gated, so a
  // gated edge is lost rather than deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      prev_q <= strobe;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign count_o = cnt_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/cache_event_profiler.sv
// Multi-cache hit/request profiler with atomic snapshot and read port.
// In: enable, clear, snapshot, hit, req, rd_en/rd_cache/rd_kind.
// Out: rd_data, rd_valid (one cycle after rd_en).
// CACHE_PROF_SATURATE_EN: counters saturate instead of wrapping.
module cache_event_profiler
  import cache_prof_pkg::*;
#(
  parameter int NUM_CACHES = NUM_CACHES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int SEL_W      =
    (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  snapshot,
  input  logic [NUM_CACHES-1:0] hit,
  input  logic [NUM_CACHES-1:0] req,
  input  logic                  rd_en,
  input  logic [SEL_W-1:0]      rd_cache,
  input  logic [1:0]            rd_kind,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  rd_valid
);

  logic [CNT_W-1:0] hit_cnt [NUM_CACHES];
  logic [CNT_W-1:0] req_cnt [NUM_CACHES];
  logic             hit_flg [NUM_CACHES];
  logic             req_flg [NUM_CACHES];

  logic [CNT_W-1:0] hit_sh_q [NUM_CACHES];
  logic [CNT_W-1:0] req_sh_q [NUM_CACHES];
  logic             hfl_sh_q [NUM_CACHES];
  logic             rfl_sh_q [NUM_CACHES];

  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic             in_range;
  logic [SEL_W-1:0] idx;
  logic [CNT_W-1:0] s_hit, s_req, s_miss;

  for (genvar g = 0; g < NUM_CACHES; g++) begin : g_cache
    prof_edge_counter #(.CNT_W(CNT_W)) u_hit (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .clear   (clear),
      .strobe  (hit[g]),
      .count_o (hit_cnt[g]),
      .flag_o  (hit_flg[g])
    );
    prof_edge_counter #(.CNT_W(CNT_W)) u_req (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .clear   (clear),
      .strobe  (req[g]),
      .count_o (req_cnt[g]),
      .flag_o  (req_flg[g])
    );
  end

  // Shadow samples the live values before this edge's
  // increment or clear lands, giving an atomic freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CACHES; i++) begin
        hit_sh_q[i] <= '0;
        req_sh_q[i] <= '0;
        hfl_sh_q[i] <= 1'b0;
        rfl_sh_q[i] <= 1'b0;
      end
    end else if (snapshot) begin
      for (int i = 0; i < NUM_CACHES; i++) begin
        hit_sh_q[i] <= hit_cnt[i];
        req_sh_q[i] <= req_cnt[i];
        hfl_sh_q[i] <= hit_flg[i];
        rfl_sh_q[i] <= req_flg[i];
      end
    end
  end

  always_comb begin
    in_range  = 32'(rd_cache) < 32'(NUM_CACHES);
    idx       = in_range ? rd_cache : '0;
    s_hit     = hit_sh_q[idx];
    s_req     = req_sh_q[idx];
    s_miss    = (s_req >= s_hit) ? s_req - s_hit : '0;
    rd_data_d = '0;
    unique case (rd_kind_t'(rd_kind))
      KIND_HIT:   rd_data_d = s_hit;
      KIND_REQ:   rd_data_d = s_req;
      KIND_MISS:  rd_data_d = s_miss;
      KIND_FLAGS: rd_data_d =
        CNT_W'({rfl_sh_q[idx], hfl_sh_q[idx]});
      default:    rd_data_d = '0;
    endcase
    if (!in_range) rd_data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_cache_event_profiler.sv
// Directed self-checking bench for cache_event_profiler.
// Three caches so index 3 is out of range; CNT_W=8 for overflow.
module tb_cache_event_profiler;
  import cache_prof_pkg::*;

  localparam int NC = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          clear;
  logic          snapshot;
  logic [NC-1:0] hit;
  logic [NC-1:0] req;
  logic          rd_en;
  logic [1:0]    rd_cache;
  logic [1:0]    rd_kind;
  logic [CW-1:0] rd_data;
  logic          rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int       cache;
    rd_kind_t kind;
    int       exp;
  } vec_t;

  vec_t vecs [11];

  cache_event_profiler #(
    .NUM_CACHES (NC),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (clear),
    .snapshot (snapshot),
    .hit      (hit),
    .req      (req),
    .rd_en    (rd_en),
    .rd_cache (rd_cache),
    .rd_kind  (rd_kind),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic pulse_hit(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      hit[c] = 1'b1;
      tick();
      hit[c] = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_req(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      req[c] = 1'b1;
      tick();
      req[c] = 1'b0;
      tick();
    end
  endtask

  task automatic snap();
    snapshot = 1'b1;
    tick();
    snapshot = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic rd(input int c, input rd_kind_t k,
                    input int exp, input string nm);
    rd_en    = 1'b1;
    rd_cache = 2'(c);
    rd_kind  = k;
    tick();
    rd_en = 1'b0;
    chk({nm, " valid"}, int'(rd_valid), 1);
    chk({nm, " data"}, int'(rd_data), exp);
    tick();
    chk({nm, " vdrop"}, int'(rd_valid), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    snapshot = 1'b0;
    hit      = '0;
    req      = '0;
    rd_en    = 1'b0;
    rd_cache = '0;
    rd_kind  = '0;

    vecs[0]  = '{0, KIND_HIT,   3};
    vecs[1]  = '{0, KIND_REQ,   5};
    vecs[2]  = '{0, KIND_MISS,  2};
    vecs[3]  = '{0, KIND_FLAGS, 0};
    vecs[4]  = '{1, KIND_HIT,   1};
    vecs[5]  = '{1, KIND_REQ,   0};
    vecs[6]  = '{2, KIND_HIT,   4};
    vecs[7]  = '{2, KIND_REQ,   2};
    vecs[8]  = '{2, KIND_MISS,  0};
    vecs[9]  = '{3, KIND_HIT,   0};
    vecs[10] = '{3, KIND_FLAGS, 0};

    tick();
    tick();
    chk("rst rd_data", int'(rd_data), 0);
    chk("rst rd_valid", int'(rd_valid), 0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;

    pulse_hit(0, 3);
    pulse_req(0, 5);

    hit[1] = 1'b1;
    repeat (10) tick();
    hit[1] = 1'b0;
    tick();

    enable = 1'b0;
    req[1] = 1'b1;
    tick();
    tick();
    enable = 1'b1;
    tick();
    tick();
    req[1] = 1'b0;
    tick();

    pulse_hit(2, 4);
    pulse_req(2, 2);

    rd(0, KIND_HIT, 0, "pre-snap shadow");
    snap();

    for (int i = 0; i < 11; i++) begin
      rd(vecs[i].cache, vecs[i].kind, vecs[i].exp,
         $sformatf("vec%0d", i));
    end

    rd_en    = 1'b1;
    rd_cache = 2'd0;
    rd_kind  = KIND_HIT;
    tick();
    chk("b2b0 valid", int'(rd_valid), 1);
    chk("b2b0 data", int'(rd_data), 3);
    rd_kind = KIND_REQ;
    tick();
    rd_en = 1'b0;
    chk("b2b1 valid", int'(rd_valid), 1);
    chk("b2b1 data", int'(rd_data), 5);
    tick();
    chk("b2b vdrop", int'(rd_valid), 0);

    do_clear();
    snap();
    rd(0, KIND_HIT, 0, "clr hit");
    rd(0, KIND_REQ, 0, "clr req");
    rd(0, KIND_MISS, 0, "clr miss");

    pulse_hit(0, 7);
    hit[0]   = 1'b1;
    snapshot = 1'b1;
    tick();
    hit[0]   = 1'b0;
    snapshot = 1'b0;
    tick();
    rd(0, KIND_HIT, 7, "snap+edge");
    snap();
    rd(0, KIND_HIT, 8, "snap after");

    hit[0] = 1'b1;
    clear  = 1'b1;
    tick();
    hit[0] = 1'b0;
    clear  = 1'b0;
    tick();
    snap();
    rd(0, KIND_HIT, 0, "clear+edge");

    pulse_hit(0, 2);
    snapshot = 1'b1;
    clear    = 1'b1;
    tick();
    snapshot = 1'b0;
    clear    = 1'b0;
    rd(0, KIND_HIT, 2, "snap+clear shadow");
    snap();
    rd(0, KIND_HIT, 0, "snap+clear live");

    pulse_hit(0, 1);
    rd_en    = 1'b1;
    rd_cache = 2'd0;
    rd_kind  = KIND_HIT;
    snapshot = 1'b1;
    tick();
    rd_en    = 1'b0;
    snapshot = 1'b0;
    chk("rd+snap data", int'(rd_data), 0);
    tick();
    rd(0, KIND_HIT, 1, "rd after snap");

    do_clear();
    pulse_req(0, 257);
    snap();
`ifdef CACHE_PROF_SATURATE_EN
    rd(0, KIND_REQ, 255, "ovf count");
`else
    rd(0, KIND_REQ, 1, "ovf count");
`endif
    rd(0, KIND_FLAGS, 2, "ovf flags");
    do_clear();
    snap();
    rd(0, KIND_FLAGS, 0, "flags cleared");

    pulse_hit(0, 1);
    snap();
    rd_en    = 1'b1;
    rd_cache = 2'd0;
    rd_kind  = KIND_HIT;
    tick();
    chk("pre-rst valid", int'(rd_valid), 1);
    chk("pre-rst data", int'(rd_data), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", int'(rd_valid), 0);
    chk("async rst data", int'(rd_data), 0);
    rd_en = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    rd(0, KIND_HIT, 0, "post-rst hit");
    rd(0, KIND_REQ, 0, "post-rst req");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_event_profiler.md
# cache_event_profiler

Parametrised multi-cache hit/request profiler, successor to the fixed two-cache profiler. It counts rising edges of per-cache hit and request strobes into CNT_W-bit counters and derives miss counts. A software-triggered snapshot freezes all counts atomically into shadow registers, which are read through an addressed, registered read port. It sits beside the CPU core and feeds the profiler's bus-facing register block.

## Interface
- NUM_CACHES, 2, number of monitored caches (≥1); index 0 = icache, 1 = dcache by convention
- CNT_W, 32, counter width in bits (8..64)
- SEL_W, $clog2(NUM_CACHES) (min 1), width of rd_cache
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  counting gate; edges while low are not counted
- clear  in  1  synchronous pulse: zero live counters and sticky flags
- snapshot  in  1  synchronous pulse: copy live counters and flags to shadow
- hit  in  NUM_CACHES  per-cache hit strobe (level; rising edge = one event)
- req  in  NUM_CACHES  per-cache request strobe (level; rising edge = one event)
- rd_en  in  1  read request
- rd_cache  in  SEL_W  cache index to read
- rd_kind  in  2  0 = hit, 1 = request, 2 = miss, 3 = flags
- rd_data  out  CNT_W  read result
- rd_valid  out  1  rd_data valid

## Operation
- Each strobe has its own edge detector. prev register resets to 0, so a strobe high at reset release counts once. prev updates every cycle regardless of enable.
- An event is counted when strobe=1, prev=0 and enable=1. An edge seen while enable=0 is lost and not deferred.
- Live counters are incremented modulo 2^CNT_W, subject to Configuration. A sticky overflow flag sets on the increment from all-ones.
- Miss value = req_shadow − hit_shadow, computed on read. The result is clamped to 0 if hit_shadow > req_shadow.
- Shadow registers reset to 0 and change only on snapshot. Reads always return shadow values, never live values.
- rd_kind=3 returns {zeros, req_flag, hit_flag}: bit0 = hit overflow, bit1 = request overflow.
- rd_cache ≥ NUM_CACHES returns 0 with rd_valid still asserted.
- Simultaneous events:
  - clear and counting edge: clear wins; the counter ends at 0.
  - snapshot and counting edge: the shadow captures the pre-increment value; the live counter increments.
  - snapshot and clear: the shadow captures the pre-clear values; live counters clear.
  - rd_en and snapshot: the read returns the old shadow contents.
- Reset mid-operation clears everything asynchronously. There is no retained state.

## Timing
- Edge to live counter: strobe sampled at edge N, counter updated at edge N+1.
- snapshot asserted at edge N: the shadow holds the values of edge N, visible to reads issued from N+1.
- Read latency is one cycle: rd_en at edge N gives rd_data/rd_valid valid after edge N+1.
- rd_valid is high for exactly one cycle per rd_en. Back-to-back reads sustain one read per cycle.
- Reset values: rd_data=0, rd_valid=0, all counters, shadows, flags and prev registers 0.
- No backpressure; rd_en is always accepted.

## Configuration
- CACHE_PROF_SATURATE_EN defined: counters stop at all-ones, and the overflow flag reads as "saturated".
- CACHE_PROF_SATURATE_EN undefined: counters wrap to 0, and the overflow flag reads as "wrapped".
- The miss clamp applies in both modes.

## Structure
- Package cache_prof_pkg holds:
  - typedef enum logic [1:0] rd_kind_t with values KIND_HIT, KIND_REQ, KIND_MISS, KIND_FLAGS
  - localparam defaults for NUM_CACHES and CNT_W
- Sub-module prof_edge_counter contains one edge detector, counter and sticky flag, with inputs clk, rst_n, enable, clear, strobe. It is instantiated 2×NUM_CACHES times.
- The top level owns the shadow registers, the miss subtract/clamp and the read mux/register.

## Test plan
- Counting, read and clear: reset, enable=1, three 1-cycle hit[0] pulses, five req[0] pulses, snapshot, then read kinds 0/1/2 for cache 0.
  - Expect 3, 5, 2; rd_valid one cycle after each rd_en.
  - Then pulse clear and snapshot; all three reads return 0.
- Level and gating: hit[1] held high 10 cycles gives count 1. A pulse while enable=0, then enable=1 with the strobe still high, gives no count.
- Simultaneous events: with hit[0] live count 7 and shadow 0, assert snapshot on the same edge as a counting hit[0] edge.
  - Shadow reads 7; a second snapshot reads 8.
  - clear plus an edge on the same cycle leaves 0.
- Overflow with CNT_W=8: 257 req[0] edges.
  - With CACHE_PROF_SATURATE_EN: count 255, flags read 2.
  - Without: count 1, flags read 2.
  - clear resets flags to 0.
- Miss clamp and bad index: 4 hits with 2 requests gives miss read 0. rd_cache=NUM_CACHES returns 0 with rd_valid=1.
- Async reset mid-read: drop rst_n between rd_en and the next edge. rd_valid and rd_data are 0 immediately and all counts read 0 after reset release.
